prefetch_aligner: RTL and testbench

Parametrised instruction prefetch queue and compressed-instruction aligner for the fetch stage. It keeps up to `NUM_REQS` word requests outstanding on the instruction memory port and buffers returned words in a `DEPTH`-entry FIFO. It splits and reassembles 16/32-bit RISC-V instructions across word boundaries and hands one instruction per cycle to decode over a valid/ready handshake. It adds over the previous fetch block:
- bounded outstanding requests;
- squashing of in-flight responses on redirect;
- error propagation with halt;
- a backpressured output.

---
 rtl/prefetch_aligner.sv | 95 +++++++++
 tb/tb_prefetch_aligner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_aligner.sv
// prefetch_aligner: bounded-outstanding instruction prefetch FIFO with 16/32-bit RISC-V aligner
module prefetch_aligner #(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter int DEPTH = 4,
  parameter int NUM_REQS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_err_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(NUM_REQS + 1);
  logic [32:0] mem [DEPTH];
  logic [CW-1:0] count, wr;
  logic [OW-1:0] outstanding, discard, inflight;
  logic [31:0] fetch_addr, out_pc, hold_addr, w0;
  logic [15:0] w1_lo;
  logic halted, hold, stale, gnt, push, pop, acc, hi, comp_raw, need1, e0, e1, err;
  // aligner view of the FIFO head, issue decision and handshake qualifiers
  always_comb begin
    w0 = mem[0][31:0];
    e0 = mem[0][32];
    w1_lo = mem[1][15:0];
    e1 = mem[1][32];
    hi = out_pc[1];
    comp_raw = hi ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11);
    need1 = hi & ~comp_raw & ~e0;
    err = e0 | (need1 & e1);
    out_valid_o = ~halted & (count != '0) & (~need1 | (count > CW'(1)));
    out_err_o = out_valid_o & err;
    out_compressed_o = out_valid_o & comp_raw & ~err;
    out_instr_o = !out_valid_o ? 32'h0 :
                  hi ? (comp_raw ? {16'h0, w0[31:16]} : {w1_lo, w0[31:16]}) :
                       (comp_raw ? {16'h0, w0[15:0]} : w0);
    out_pc_o = out_pc;
    instr_req_o = rstn & (hold | (~halted & (32'(outstanding) - 32'(discard) + 32'(count) < DEPTH)
                                  & (32'(outstanding) < NUM_REQS)));
    instr_addr_o = hold ? hold_addr : fetch_addr;
    gnt = instr_req_o & instr_gnt_i;
    acc = out_valid_o & out_ready_i & ~redirect_i;
    pop = acc & (hi | ~out_compressed_o);
    push = instr_rvalid_i & ~redirect_i & (discard == '0);
    wr = count - CW'(pop);
    inflight = outstanding + OW'(gnt) - OW'(instr_rvalid_i);
  end
  // fetch pointers, request bookkeeping, FIFO and halt state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
      fetch_addr <= PC_RESET & ~32'h3;
      hold_addr <= PC_RESET & ~32'h3;
      out_pc <= PC_RESET;
      halted <= 1'b0;
      hold <= 1'b0;
      stale <= 1'b0;
    end else begin
      hold <= instr_req_o & ~instr_gnt_i;
      hold_addr <= instr_addr_o;
      stale <= instr_req_o & ~instr_gnt_i & (redirect_i | stale);
      outstanding <= inflight;
      if (redirect_i) begin
        count <= '0;
        halted <= 1'b0;
        out_pc <= redirect_pc_i & ~32'h1;
        fetch_addr <= redirect_pc_i & ~32'h3;
        discard <= inflight;
      end else begin
        discard <= discard + OW'(gnt & stale) - OW'(instr_rvalid_i & (discard != '0));
        if (gnt && !stale) fetch_addr <= fetch_addr + 32'd4;
        if (acc) out_pc <= out_pc + (out_compressed_o ? 32'd2 : 32'd4);
        if (acc && out_err_o) halted <= 1'b1;
        count <= count + CW'(push) - CW'(pop);
        for (int i = 0; i < DEPTH - 1; i++) if (pop) mem[i] <= mem[i+1];
        for (int i = 0; i < DEPTH; i++) if (push && CW'(i) == wr) mem[i] <= {instr_err_i, instr_rdata_i};
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rstn) !(push && !pop && 32'(count) == DEPTH));
endmodule

// File: tb/tb_prefetch_aligner.sv
// tb_prefetch_aligner: randomized memory responder with a program-walk reference model
module tb_prefetch_aligner;
  localparam int DEPTH = 4;
  localparam int NUM_REQS = 2;
  logic clk = 1'b0, rstn = 1'b0;
  logic instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, redirect_i, out_valid_o, out_ready_i;
  logic out_compressed_o, out_err_o;
  logic [31:0] instr_addr_o, instr_rdata_i, redirect_pc_i, out_instr_o, out_pc_o;
  typedef struct {logic [31:0] a; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins; logic c; logic e;} rec_t;
  logic [31:0] mw [1024];
  logic me [1024];
  req_t pend[$];
  rec_t acc_log[$];
  logic [31:0] gnt_log[$];
  int checks = 0, failures = 0, cyc = 0, mark = 0;
  int gnt_pct = 100, rv_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit do_redir = 0, mhalt = 0, prev_hold = 0, stale_hold = 0;
  logic [31:0] redir_pc = '0, mpc = '0, exp_addr = '0, prev_addr = '0;

  always #5 clk = ~clk;

  prefetch_aligner #(.PC_RESET(32'h100), .DEPTH(DEPTH), .NUM_REQS(NUM_REQS)) dut (
    .clk(clk), .rstn(rstn), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
    .out_pc_o(out_pc_o), .out_compressed_o(out_compressed_o), .out_err_o(out_err_o));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mw[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // the instruction a program walk finds at pc, with errors of every word it touches
  function automatic rec_t ref_at(input logic [31:0] pc);
    rec_t r;
    logic [15:0] lo;
    logic [31:0] p2;
    lo = half(pc);
    p2 = pc + 32'd2;
    r.pc = pc;
    r.e = me[pc[11:2]];
    r.c = lo[1:0] != 2'b11;
    r.ins = r.c ? {16'h0, lo} : {half(p2), lo};
    if (!r.c) r.e = r.e | me[p2[11:2]];
    if (r.e) r.c = 1'b0;
    return r;
  endfunction

  function automatic rec_t logged(input int i);
    rec_t z;
    z = '{pc: '0, ins: '0, c: 1'b0, e: 1'b0};
    return i < acc_log.size() ? acc_log[i] : z;
  endfunction

  task automatic step();
    rec_t r;
    bit rv, acc, nh;
    int lat;
    @(negedge clk);
    cyc++;
    if (prev_hold) begin
      check("hold_req", {31'b0, instr_req_o}, 32'd1);
      check("hold_addr", instr_addr_o, prev_addr);
    end
    if (mhalt) begin
      check("halt_valid", {31'b0, out_valid_o}, 32'd0);
      if (!prev_hold) check("halt_req", {31'b0, instr_req_o}, 32'd0);
    end
    rv = pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct;
    instr_gnt_i = $urandom_range(99) < gnt_pct;
    instr_rvalid_i = rv;
    instr_rdata_i = $urandom;
    instr_err_i = 1'($urandom);
    if (rv) begin
      instr_rdata_i = mw[pend[0].a[11:2]];
      instr_err_i = me[pend[0].a[11:2]];
    end
    out_ready_i = $urandom_range(99) < rdy_pct;
    redirect_i = do_redir;
    redirect_pc_i = redir_pc;
    do_redir = 0;
    acc = out_valid_o && out_ready_i && !redirect_i;
    if (acc) begin
      r = ref_at(mpc);
      check("out_pc", out_pc_o, r.pc);
      check("out_err", {31'b0, out_err_o}, {31'b0, r.e});
      check("out_comp", {31'b0, out_compressed_o}, {31'b0, r.c});
      if (!r.e) check("out_instr", out_instr_o, r.ins);
      acc_log.push_back('{pc: out_pc_o, ins: out_instr_o, c: out_compressed_o, e: out_err_o});
      mpc = mpc + (r.c ? 32'd2 : 32'd4);
      if (r.e) mhalt = 1;
    end
    if (instr_req_o && instr_gnt_i) begin
      if (!stale_hold) begin
        check("req_addr", instr_addr_o, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      lat = int'($urandom_range(lat_max, lat_min));
      pend.push_back('{a: instr_addr_o, due: cyc + lat});
      gnt_log.push_back(instr_addr_o);
      check("outstanding_le", {31'b0, pend.size() <= NUM_REQS}, 32'd1);
    end
    if (rv) void'(pend.pop_front());
    nh = instr_req_o && !instr_gnt_i;
    stale_hold = nh && (redirect_i || stale_hold);
    prev_hold = nh;
    prev_addr = instr_addr_o;
    if (redirect_i) begin
      mpc = redir_pc & ~32'h1;
      exp_addr = redir_pc & ~32'h3;
      mhalt = 0;
      gnt_log.delete();
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    do_redir = 1;
    redir_pc = pc;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mw[i] = i < 512 ? ($urandom | 32'h3) : $urandom;
      me[i] = i < 512 ? 1'b0 : ($urandom_range(29) == 0);
    end
    mw[32'h100 >> 2] = 32'h0001_4501;
    mw[32'h104 >> 2] = 32'h0000_0013;
    mw[32'h204 >> 2] = 32'h4501_0013;
    mw[32'h300 >> 2] = 32'h0013_FFFF;
    mw[32'h304 >> 2] = 32'h0000_00A0;
    me[32'h500 >> 2] = 1'b1;
    {instr_gnt_i, instr_rvalid_i, instr_err_i, redirect_i, out_ready_i} = '0;
    instr_rdata_i = '0;
    redirect_pc_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, instr_req_o}, 32'd0);
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_err", {31'b0, out_err_o}, 32'd0);
    check("rst_comp", {31'b0, out_compressed_o}, 32'd0);
    check("rst_instr", out_instr_o, 32'h0);
    check("rst_pc", out_pc_o, 32'h100);
    check("rst_addr", instr_addr_o, 32'h100);
    rstn = 1'b1;
    #1;
    check("req_rise", {31'b0, instr_req_o}, 32'd1);
    mpc = 32'h100;
    exp_addr = 32'h100;
    prev_hold = 1;
    prev_addr = 32'h100;
    repeat (24) step();
    check("mixed0_pc", logged(0).pc, 32'h100);
    check("mixed0_ins", logged(0).ins, 32'h4501);
    check("mixed0_c", {31'b0, logged(0).c}, 32'd1);
    check("mixed1_pc", logged(1).pc, 32'h102);
    check("mixed1_ins", logged(1).ins, 32'h0001);
    check("mixed1_c", {31'b0, logged(1).c}, 32'd1);
    check("mixed2_pc", logged(2).pc, 32'h104);
    check("mixed2_ins", logged(2).ins, 32'h13);
    check("mixed2_c", {31'b0, logged(2).c}, 32'd0);
    mark = acc_log.size();
    repeat (16) step();
    check("throughput", acc_log.size() - mark, 32'd16);
    lat_min = 3;
    lat_max = 3;
    mark = acc_log.size();
    redirect_to(32'h302);
    repeat (20) step();
    check("unal_pc", logged(mark).pc, 32'h302);
    check("unal_ins", logged(mark).ins, 32'h00A0_0013);
    check("unal_c", {31'b0, logged(mark).c}, 32'd0);
    for (int i = 0; i < 20 && pend.size() != 2; i++) step();
    check("two_outstanding", pend.size(), 32'd2);
    mark = acc_log.size();
    redirect_to(32'h206);
    repeat (15) step();
    check("redir_addr", gnt_log.size() > 0 ? gnt_log[0] : 32'h0, 32'h204);
    check("redir_pc", logged(mark).pc, 32'h206);
    check("redir_ins", logged(mark).ins, 32'h4501);
    lat_min = 1;
    lat_max = 1;
    rdy_pct = 0;
    redirect_to(32'h400);
    repeat (10) step();
    check("stall_grants", gnt_log.size(), 32'd4);
    check("stall_req", {31'b0, instr_req_o}, 32'd0);
    check("stall_valid", {31'b0, out_valid_o}, 32'd1);
    rdy_pct = 100;
    repeat (20) step();
    mark = acc_log.size();
    redirect_to(32'h500);
    repeat (8) step();
    check("err_pc", logged(mark).pc, 32'h500);
    check("err_flag", {31'b0, logged(mark).e}, 32'd1);
    check("err_comp", {31'b0, logged(mark).c}, 32'd0);
    check("halt_valid_end", {31'b0, out_valid_o}, 32'd0);
    check("halt_req_end", {31'b0, instr_req_o}, 32'd0);
    mark = acc_log.size();
    redirect_to(32'h400);
    repeat (10) step();
    check("resume_pc", logged(mark).pc, 32'h400);
    mark = acc_log.size();
    repeat (12) begin
      gnt_pct = int'($urandom_range(100, 40));
      rv_pct = int'($urandom_range(100, 40));
      rdy_pct = int'($urandom_range(100, 30));
      lat_max = int'($urandom_range(3, 1));
      redirect_to(32'h800 + $urandom_range(32'h5FF));
      repeat (60 + $urandom_range(40)) step();
    end
    check("rand_progress", {31'b0, acc_log.size() > mark + 50}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
